// File: rtl/sobel_frame_seq.sv
// Frame sequencer for the 3x3 Sobel datapath: counts accepted pixels, gates the
// line-buffer shift, and emits window-centre coordinates, edge flags and valid.
module sobel_frame_seq #(
  parameter int WIDTH  = 640,
  parameter int HEIGHT = 480,
  parameter int LAG    = WIDTH + 1
) (
  input  logic       iCLK,
  input  logic       iRST,
  input  logic       iEnable,
  input  logic       iFrameStart,
  input  logic       iDVAL,
  input  logic       iFilterReq,
  input  logic       iErrClr,
  output logic       oShiftEn,
  output logic       oFlushPix,
  output logic       oFilter,
  output logic       oDVAL,
  output logic [9:0] oCX,
  output logic [9:0] oCY,
  output logic       oEdgeN,
  output logic       oEdgeS,
  output logic       oEdgeW,
  output logic       oEdgeE,
  output logic       oFrameDone,
  output logic       oBusy,
  output logic [1:0] oState,
  output logic       oErr
);

  localparam logic [1:0] S_IDLE  = 2'd0;
  localparam logic [1:0] S_FILL  = 2'd1;
  localparam logic [1:0] S_RUN   = 2'd2;
  localparam logic [1:0] S_DRAIN = 2'd3;

  localparam int DW = $clog2(LAG + 1);
  localparam logic [18:0]   FILL_LAST  = 19'(LAG - 1);
  localparam logic [18:0]   PIX_LAST   = 19'(WIDTH * HEIGHT - 1);
  localparam logic [DW-1:0] DRAIN_LAST = DW'(LAG - 1);
  localparam logic [9:0]    X_LAST     = 10'(WIDTH - 1);
  localparam logic [9:0]    Y_LAST     = 10'(HEIGHT - 1);

  logic [1:0]    state_q, state_d;
  logic [18:0]   in_cnt_q, in_cnt_d;
  logic [9:0]    cx_q, cx_d, cy_q, cy_d;
  logic [DW-1:0] drain_q, drain_d;
  logic          filter_q, filter_d;
  logic          err_q, err_d;
  logic          done_q, done_d;

  logic start, fill_acc, run_acc, drain_step, err_set;

  // A start in any non-IDLE state is an abort-and-restart and ignores iEnable.
  assign start      = iFrameStart & ((state_q != S_IDLE) | iEnable);
  assign fill_acc   = ~start & iDVAL & (state_q == S_FILL);
  assign run_acc    = ~start & iDVAL & (state_q == S_RUN);
  assign drain_step = ~start & (state_q == S_DRAIN);
  assign err_set    = (iFrameStart & (state_q != S_IDLE)) | (iDVAL & (state_q == S_DRAIN));

  assign oShiftEn   = (start & iDVAL) | fill_acc | run_acc | drain_step;
  assign oFlushPix  = drain_step;
  assign oDVAL      = run_acc | drain_step;
  assign oFilter    = filter_q;
  assign oCX        = cx_q;
  assign oCY        = cy_q;
  assign oEdgeN     = (cy_q == 10'd0);
  assign oEdgeS     = (cy_q == Y_LAST);
  assign oEdgeW     = (cx_q == 10'd0);
  assign oEdgeE     = (cx_q == X_LAST);
  assign oFrameDone = done_q;
  assign oBusy      = (state_q != S_IDLE);
  assign oState     = state_q;
  assign oErr       = err_q;

  always_comb begin
    state_d  = state_q;
    in_cnt_d = in_cnt_q;
    cx_d     = cx_q;
    cy_d     = cy_q;
    drain_d  = drain_q;
    filter_d = filter_q;
    done_d   = 1'b0;
    err_d    = err_set | (err_q & ~iErrClr);

    if (oDVAL) begin
      if (cx_q == X_LAST) begin
        cx_d = 10'd0;
        cy_d = (cy_q == Y_LAST) ? 10'd0 : cy_q + 10'd1;
      end else begin
        cx_d = cx_q + 10'd1;
      end
    end

    if (start) begin
      // A pixel arriving with the start pulse is pixel 0.
      state_d  = S_FILL;
      filter_d = iFilterReq;
      in_cnt_d = iDVAL ? 19'd1 : 19'd0;
      cx_d     = 10'd0;
      cy_d     = 10'd0;
      drain_d  = '0;
    end else begin
      case (state_q)
        S_FILL: if (fill_acc) begin
          in_cnt_d = in_cnt_q + 19'd1;
          if (in_cnt_q == FILL_LAST) state_d = S_RUN;
        end
        S_RUN: if (run_acc) begin
          in_cnt_d = in_cnt_q + 19'd1;
          if (in_cnt_q == PIX_LAST) begin
            state_d = S_DRAIN;
            drain_d = '0;
          end
        end
        S_DRAIN: begin
          drain_d = drain_q + 1'b1;
          if (drain_q == DRAIN_LAST) begin
            state_d = S_IDLE;
            done_d  = 1'b1;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge iCLK or negedge iRST) begin
    if (!iRST) begin
      state_q  <= S_IDLE;
      in_cnt_q <= '0;
      cx_q     <= '0;
      cy_q     <= '0;
      drain_q  <= '0;
      filter_q <= 1'b0;
      err_q    <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      in_cnt_q <= in_cnt_d;
      cx_q     <= cx_d;
      cy_q     <= cy_d;
      drain_q  <= drain_d;
      filter_q <= filter_d;
      err_q    <= err_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_sobel_frame_seq.sv
// Scoreboard bench for sobel_frame_seq on an 8x4 frame: the driver pushes the
// expected window centres, a negedge monitor pops and compares on every oDVAL.
module tb_sobel_frame_seq;
  localparam int W = 8;
  localparam int H = 4;
  localparam int LAG = W + 1;
  localparam int N = W * H;

  logic iCLK = 1'b0, iRST = 1'b0;
  logic iEnable = 1'b0, iFrameStart = 1'b0, iDVAL = 1'b0, iFilterReq = 1'b0, iErrClr = 1'b0;
  logic oShiftEn, oFlushPix, oFilter, oDVAL;
  logic [9:0] oCX, oCY;
  logic oEdgeN, oEdgeS, oEdgeW, oEdgeE, oFrameDone, oBusy, oErr;
  logic [1:0] oState;

  sobel_frame_seq #(.WIDTH(W), .HEIGHT(H), .LAG(LAG)) dut (
    .iCLK(iCLK), .iRST(iRST), .iEnable(iEnable), .iFrameStart(iFrameStart),
    .iDVAL(iDVAL), .iFilterReq(iFilterReq), .iErrClr(iErrClr),
    .oShiftEn(oShiftEn), .oFlushPix(oFlushPix), .oFilter(oFilter), .oDVAL(oDVAL),
    .oCX(oCX), .oCY(oCY), .oEdgeN(oEdgeN), .oEdgeS(oEdgeS), .oEdgeW(oEdgeW),
    .oEdgeE(oEdgeE), .oFrameDone(oFrameDone), .oBusy(oBusy), .oState(oState), .oErr(oErr)
  );

  always #5 iCLK = ~iCLK;

  typedef struct packed {
    logic [9:0] cx, cy;
    logic n, s, w, e, f, fl;
    logic last;
  } rec_t;

  rec_t q[$];
  int   errors = 0, checks = 0;
  int   sent = 0, pop_cnt = 0, done_cnt = 0;
  bit   drv_acc = 0, cur_flt = 0, in_frame = 0, done_pend = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference: centre c of a raster-order frame sits at (c mod W, c div W).
  function automatic void push_c(input int c, input bit fl);
    rec_t r;
    r.cx = 10'(c % W);
    r.cy = 10'(c / W);
    r.n = (c / W) == 0;
    r.s = (c / W) == H - 1;
    r.w = (c % W) == 0;
    r.e = (c % W) == W - 1;
    r.f = cur_flt;
    r.fl = fl;
    r.last = (c == N - 1);
    q.push_back(r);
  endfunction

  always @(negedge iCLK) begin
    bit pend;
    rec_t r;
    if (iRST) begin
      pend = done_pend;
      done_pend = 0;
      chk("shift_en", {31'd0, oShiftEn}, {31'd0, drv_acc | oFlushPix});
      if (pend) begin
        chk("frame_done_pulse", {29'd0, oFrameDone, oState}, {29'd0, 1'b1, 2'd0});
        done_cnt++;
      end else if (oFrameDone) begin
        chk("spurious_frame_done", {31'd0, oFrameDone}, 32'd0);
      end
      if (oDVAL) begin
        if (q.size() == 0) begin
          chk("unexpected_dval", {22'd0, oCX}, 32'hffff_ffff);
        end else begin
          r = q.pop_front();
          pop_cnt++;
          chk("centre", {6'd0, oCX, oCY, oEdgeN, oEdgeS, oEdgeW, oEdgeE, oFilter, oFlushPix},
              {6'd0, r.cx, r.cy, r.n, r.s, r.w, r.e, r.f, r.fl});
          if (r.last) done_pend = 1;
        end
      end
    end
  end

  task automatic idle_cycle(input bit dv = 0);
    @(posedge iCLK); #1;
    iFrameStart = 0; iDVAL = dv; iErrClr = 0; drv_acc = 0;
  endtask

  task automatic do_start(input bit flt, input bit dv, input bit en);
    @(posedge iCLK); #1;
    iFrameStart = 1; iEnable = en; iFilterReq = flt; iDVAL = dv; iErrClr = 0;
    if (en || in_frame) begin
      in_frame = 1; cur_flt = flt; sent = dv ? 1 : 0; pop_cnt = 0; drv_acc = dv;
    end else begin
      drv_acc = 0;
    end
  endtask

  task automatic send_pixels(input int upto, input int duty);
    bit v;
    while (sent < upto) begin
      @(posedge iCLK); #1;
      iFrameStart = 0; iErrClr = 0;
      iEnable = 1'($urandom); iFilterReq = 1'($urandom);
      v = ($urandom_range(duty - 1) == 0);
      iDVAL = v; drv_acc = v;
      if (v) begin
        if (sent >= LAG) push_c(sent - LAG, 0);
        sent++;
      end
    end
  endtask

  task automatic finish_frame(input bit dv_in_drain);
    int d0, t;
    d0 = done_cnt;
    idle_cycle(dv_in_drain);
    for (int c = N - LAG; c < N; c++) push_c(c, 1);
    t = 0;
    while (done_cnt == d0 && t < 4 * LAG) begin
      idle_cycle(0);
      t++;
    end
    chk("frame_completed", {31'd0, done_cnt != d0}, 32'd1);
    chk("dval_count", pop_cnt, N);
    chk("queue_empty", q.size(), 0);
    in_frame = 0;
  endtask

  task automatic full_frame(input bit flt, input bit dv0, input int duty);
    do_start(flt, dv0, 1);
    send_pixels(N, duty);
    finish_frame(0);
    idle_cycle();
    chk("state_idle_after", {30'd0, oState}, 32'd0);
  endtask

  initial begin
    repeat (3) @(posedge iCLK);
    #1;
    chk("rst_ctrl", {24'd0, oState, oBusy, oDVAL, oShiftEn, oFlushPix, oFrameDone, oErr}, 32'd0);
    chk("rst_coord", {11'd0, oCX, oCY, oFilter}, 32'd0);
    chk("rst_edges", {28'd0, oEdgeN, oEdgeS, oEdgeW, oEdgeE}, {28'd0, 4'b1010});
    iRST = 1;
    iEnable = 1;
    idle_cycle();

    full_frame(0, 0, 1);
    full_frame(1, 1, 3);
    full_frame(0, 0, 2);

    // Abort at pixel 15 with a restart while iEnable is low.
    do_start(0, 0, 1);
    send_pixels(15, 1);
    do_start(1, 0, 0);
    idle_cycle();
    chk("abort_err_set", {29'd0, oErr, oState}, {29'd0, 1'b1, 2'd1});
    chk("abort_filter", {31'd0, oFilter}, 32'd1);
    iErrClr = 1;
    idle_cycle();
    chk("err_cleared", {31'd0, oErr}, 32'd0);
    send_pixels(N, 2);
    finish_frame(0);
    idle_cycle();

    // iDVAL during drain flags an error without disturbing the drain.
    do_start(0, 1, 1);
    send_pixels(N, 1);
    finish_frame(1);
    chk("drain_dval_err", {31'd0, oErr}, 32'd1);
    iErrClr = 1;
    idle_cycle();
    chk("drain_err_clr", {31'd0, oErr}, 32'd0);

    // Start in IDLE with iEnable low is ignored.
    do_start(1, 1, 0);
    idle_cycle();
    chk("no_start_disabled", {29'd0, oBusy, oState}, 32'd0);
    chk("no_start_err", {31'd0, oErr}, 32'd0);
    iEnable = 1;

    // Asynchronous reset mid-RUN.
    do_start(1, 0, 1);
    send_pixels(20, 1);
    @(posedge iCLK); #1;
    iRST = 0; iDVAL = 0; iFrameStart = 0; drv_acc = 0; in_frame = 0;
    #1;
    chk("mid_rst_ctrl", {24'd0, oState, oBusy, oDVAL, oShiftEn, oFlushPix, oFrameDone, oErr}, 32'd0);
    chk("mid_rst_coord", {11'd0, oCX, oCY, oFilter}, 32'd0);
    chk("mid_rst_edges", {28'd0, oEdgeN, oEdgeS, oEdgeW, oEdgeE}, {28'd0, 4'b1010});
    q.delete();
    repeat (2) @(posedge iCLK);
    #1 iRST = 1;
    full_frame(0, 1, 2);

    repeat (2) @(posedge iCLK);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1);
  end
endmodule
